treeval: RTL and testbench



---
 rtl/treeval_pkg.sv | 9 +
 rtl/treeval_pe.sv | 31 +++
 rtl/treeval.sv | 108 ++++++++++
 tb/tb_treeval.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/treeval_pkg.sv
// treeval_pkg: shared constants and FSM state type for the game-tree evaluator
package treeval_pkg;
   localparam logic       STRAT_MAX   = 1'b1;
   localparam logic       STRAT_MIN   = 1'b0;
   localparam logic [2:0] ACT_PLAY    = 3'b001;
   localparam logic [2:0] ACT_NO_PLAY = 3'b000;
   localparam int         W_FRAC      = 7;
   typedef enum logic [1:0] {INIT, EVAL, DONE, HOLD} state_t;
endpackage

// File: rtl/treeval_pe.sv
// treeval_pe: weighted child value and max/min replace decision for one tree edge
// Ports: val/weight -> wv = (val*weight)>>>W_FRAC truncated (or saturated when
// TREEVAL_SAT_EN is defined); strat/has_best/best -> upd = child should replace
// the parent's current best.
module treeval_pe import treeval_pkg::*; #(
   parameter int W_REWARD = 10,
   parameter int W_N_DATA = 10
) (
   input  logic signed [W_REWARD-1:0] val,
   input  logic        [W_N_DATA-1:0] weight,
   input  logic                       strat,
   input  logic                       has_best,
   input  logic signed [W_REWARD-1:0] best,
   output logic signed [W_REWARD-1:0] wv,
   output logic                       upd
);
   localparam int W_P = W_REWARD + W_N_DATA;
   logic signed [W_P-1:0] prod, shifted;
   assign prod    = $signed({{W_N_DATA{val[W_REWARD-1]}}, val}) * $signed({{W_REWARD{1'b0}}, weight});
   assign shifted = prod >>> W_FRAC;
`ifdef TREEVAL_SAT_EN
   localparam logic signed [W_P-1:0] SAT_HI = W_P'(2 ** (W_REWARD - 1) - 1);
   localparam logic signed [W_P-1:0] SAT_LO = W_P'(-(2 ** (W_REWARD - 1)));
   assign wv = (shifted > SAT_HI) ? SAT_HI[W_REWARD-1:0] :
               (shifted < SAT_LO) ? SAT_LO[W_REWARD-1:0] : shifted[W_REWARD-1:0];
`else
   assign wv = shifted[W_REWARD-1:0];
`endif
   // strict compare: on ties the earlier-visited (higher-index) child stays
   assign upd = !has_best || (strat ? wv > best : wv < best);
endmodule

// File: rtl/treeval.sv
// treeval: bottom-up max/min game-tree evaluator with host-loaded configuration
// Ports: clk, rst (async active-high, release starts evaluation);
// mem_weight/mem_par/mem_rew/mem_act + mem_addr/mem_data load per-node arrays;
// conf_nodes + conf_data load the node count; exp/act/exp_change report the
// root value, winning root-child action and freshness.
// Optional: define TREEVAL_SAT_EN to saturate weighted values instead of wrapping.
module treeval import treeval_pkg::*; #(
   parameter int W_ADDR   = 10,
   parameter int W_N_DATA = 10,
   parameter int W_C_DATA = 10,
   parameter int W_REWARD = 10,
   parameter int W_ACTION = 3
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       mem_weight,
   input  logic                       mem_par,
   input  logic                       mem_rew,
   input  logic                       mem_act,
   input  logic        [W_ADDR-1:0]   mem_addr,
   input  logic        [W_N_DATA-1:0] mem_data,
   input  logic                       conf_nodes,
   input  logic        [W_C_DATA-1:0] conf_data,
   output logic                       exp_change,
   output logic signed [W_REWARD-1:0] exp,
   output logic        [W_ACTION-1:0] act
);
   localparam int CAP = 2 ** W_ADDR;
   logic        [W_ADDR:0]     n_nodes;
   logic        [W_ADDR-1:0]   parent  [CAP];
   logic signed [W_REWARD-1:0] reward  [CAP];
   logic        [W_N_DATA-1:0] weight  [CAP];
   logic        [W_ACTION-1:0] action  [CAP];
   logic        [CAP-1:0]      strat;
   logic signed [W_REWARD-1:0] best    [CAP];
   logic        [W_ACTION-1:0] bestact [CAP];
   logic        [CAP-1:0]      has_child;
   state_t                     state;
   logic        [W_ADDR-1:0]   idx, p;
   logic signed [W_REWARD-1:0] val, wv;
   logic                       upd, do_upd, wr_en, any_wr;
   logic        [31:0]         conf_ext;
   assign wr_en    = state != EVAL;
   assign any_wr   = wr_en && (mem_weight || mem_par || mem_rew || mem_act || conf_nodes);
   assign conf_ext = 32'(conf_data);
   // configuration is deliberately outside the reset domain so it survives rst
   always_ff @(posedge clk) begin
      if (wr_en && mem_weight) weight[mem_addr] <= mem_data;
      if (wr_en && mem_par) parent[mem_addr] <= mem_data[W_ADDR-1:0];
      if (wr_en && mem_rew) reward[mem_addr] <= mem_data[W_REWARD-1:0];
      if (wr_en && mem_act) begin
         strat[mem_addr]  <= mem_data[3];
         action[mem_addr] <= mem_data[W_ACTION-1:0];
      end
      if (wr_en && conf_nodes)
         n_nodes <= (conf_ext > 32'(CAP)) ? (W_ADDR+1)'(CAP) : (W_ADDR+1)'(conf_ext);
   end
   assign p   = parent[idx];
   assign val = has_child[idx] ? best[idx] : reward[idx];
   treeval_pe #(.W_REWARD(W_REWARD), .W_N_DATA(W_N_DATA)) u_pe (
      .val(val),
      .weight(weight[idx]),
      .strat(strat[p]),
      .has_best(has_child[p]),
      .best(best[p]),
      .wv(wv),
      .upd(upd)
   );
   // nodes pointing at themselves or forward are skipped entirely
   assign do_upd = state == EVAL && p < idx && upd;
   // best/bestact are only meaningful where has_child is set, so they need no reset
   always_ff @(posedge clk) begin
      if (state == INIT) has_child <= '0;
      else if (do_upd) begin
         has_child[p] <= 1'b1;
         best[p]      <= wv;
         bestact[p]   <= action[idx];
      end
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= INIT;
         idx        <= '0;
         exp        <= '0;
         act        <= '0;
         exp_change <= 1'b0;
      end else begin
         if (any_wr) exp_change <= 1'b0;
         unique case (state)
            INIT: begin
               idx   <= (n_nodes > (W_ADDR+1)'(1)) ? W_ADDR'(n_nodes - 1'b1) : '0;
               state <= (n_nodes > (W_ADDR+1)'(1)) ? EVAL : DONE;
            end
            EVAL: begin
               idx   <= idx - 1'b1;
               state <= (idx == W_ADDR'(1)) ? DONE : EVAL;
            end
            DONE: begin
               exp        <= has_child[0] ? best[0] : '0;
               act        <= has_child[0] ? bestact[0] : '0;
               exp_change <= !any_wr;
               state      <= HOLD;
            end
            HOLD: state <= HOLD;
         endcase
      end
   end
endmodule

// File: tb/tb_treeval.sv
// tb_treeval: randomized scoreboard bench for treeval against a recursive-rule reference model
module tb_treeval;
   import treeval_pkg::*;
   logic              clk = 0, rst = 1;
   logic              mem_weight = 0, mem_par = 0, mem_rew = 0, mem_act = 0, conf_nodes = 0;
   logic        [9:0] mem_addr = 0, mem_data = 0, conf_data = 0;
   logic              exp_change;
   logic signed [9:0] exp;
   logic        [2:0] act;
   treeval dut (
      .clk(clk), .rst(rst), .mem_weight(mem_weight), .mem_par(mem_par), .mem_rew(mem_rew),
      .mem_act(mem_act), .mem_addr(mem_addr), .mem_data(mem_data), .conf_nodes(conf_nodes),
      .conf_data(conf_data), .exp_change(exp_change), .exp(exp), .act(act)
   );
   always #5 clk = ~clk;
   int vectors = 0, errs = 0, cyc = 0, rel_cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;
   typedef struct {int e; int a; int lat;} exp_t;
   exp_t sb[$];
   int m_par[1024], m_rew[1024], m_wt[1024], m_strat[1024], m_act[1024];
   int m_n = 0;
   task automatic chk(input string nm, input int got, input int want);
      vectors++;
      if (got !== want) begin
         errs++;
         $display("FAIL %s: got %0d expected %0d", nm, got, want);
      end
   endtask
   function automatic int wfun(input int v, input int w);
      int x;
      logic signed [9:0] t;
      x = (v * w) >>> 7;
`ifdef TREEVAL_SAT_EN
      return x > 511 ? 511 : x < -512 ? -512 : x;
`else
      t = x[9:0];
      return int'(t);
`endif
   endfunction
   // value of a node = its reward if nobody names it as parent, otherwise the
   // best weighted child value; ascending scan with >=/<= lets the highest index win ties
   function automatic void model(output int e, output int a);
      int v[1024];
      int b, ba, w;
      bit any;
      e = 0;
      a = 0;
      for (int q = m_n - 1; q >= 0; q--) begin
         any = 0;
         b = 0;
         ba = 0;
         for (int j = q + 1; j < m_n; j++)
            if (m_par[j] == q) begin
               w = wfun(v[j], m_wt[j]);
               if (!any || (m_strat[q] != 0 ? w >= b : w <= b)) begin
                  b = w;
                  ba = m_act[j];
               end
               any = 1;
            end
         v[q] = any ? b : m_rew[q];
         if (q == 0 && any) begin
            e = b;
            a = ba;
         end
      end
   endfunction
   task automatic wr(input int kind, input int addr, input int data);
      mem_addr = 10'(addr);
      mem_data = 10'(data);
      conf_data = 10'(data);
      mem_weight = kind == 0;
      mem_par = kind == 1;
      mem_rew = kind == 2;
      mem_act = kind == 3;
      conf_nodes = kind == 4;
      @(negedge clk);
      {mem_weight, mem_par, mem_rew, mem_act, conf_nodes} = '0;
      case (kind)
         0: m_wt[addr] = data;
         1: m_par[addr] = data;
         2: m_rew[addr] = data;
         3: begin m_strat[addr] = (data >> 3) & 1; m_act[addr] = data & 7; end
         default: m_n = data;
      endcase
   endtask
   task automatic node(input int i, input int par, input int rew, input int wt, input int st, input int ac);
      wr(1, i, par);
      wr(2, i, rew);
      wr(0, i, wt);
      wr(3, i, st * 8 + ac);
   endtask
   task automatic wait_done();
      for (int k = 0; k < 3000 && sb.size() > 0; k++) @(negedge clk);
      chk("done_timeout", sb.size(), 0);
      sb.delete();
      @(negedge clk);
   endtask
   task automatic release_rst();
      int e, a;
      model(e, a);
      sb.push_back('{e, a, (m_n <= 1) ? 2 : m_n + 1});
      rst = 0;
      rel_cyc = cyc;
   endtask
   task automatic run();
      rst = 1;
      @(negedge clk);
      release_rst();
      wait_done();
   endtask
   initial begin : monitor
      bit prev;
      exp_t x;
      prev = 0;
      forever begin
         @(negedge clk);
         if (exp_change && !prev) begin
            if (sb.size() == 0) chk("spurious_result", 1, 0);
            else begin
               x = sb.pop_front();
               chk("exp", int'(exp), x.e);
               chk("act", int'(act), x.a);
               chk("latency", cyc - rel_cyc, x.lat);
            end
         end
         prev = exp_change;
      end
   end
   initial begin
      #5ms;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1);
   end
   initial begin
      @(negedge clk);
      chk("rst_exp", int'(exp), 0);
      chk("rst_act", int'(act), 0);
      chk("rst_flag", int'(exp_change), 0);
      wr(4, 0, 7);
      wr(3, 0, 8);
      node(1, 0, 0, 64, 1, ACT_PLAY);
      node(2, 0, -10, 64, 1, ACT_PLAY);
      node(3, 0, 0, 128, 1, ACT_NO_PLAY);
      node(4, 1, 100, 64, 1, ACT_PLAY);
      node(5, 1, -50, 64, 1, ACT_PLAY);
      node(6, 1, 10, 128, 1, ACT_NO_PLAY);
      run();
      chk("base_exp", int'(exp), 25);
      chk("base_act", int'(act), 1);
      wr(2, 3, 0);
      chk("stale_flag", int'(exp_change), 0);
      chk("stale_exp", int'(exp), 25);
      wr(3, 0, 0);
      run();
      chk("min_exp", int'(exp), -5);
      chk("min_act", int'(act), 1);
      wr(3, 0, 8);
      wr(2, 2, 50);
      run();
      chk("tie_exp", int'(exp), 25);
      chk("tie_act", int'(act), 1);
      wr(2, 2, -10);
      run();
      // abort three cycles into EVAL; a write landing during EVAL must be dropped
      rst = 1;
      @(negedge clk);
      rst = 0;
      repeat (2) @(negedge clk);
      mem_addr = 10'd4;
      mem_data = 10'd0;
      mem_rew = 1;
      @(negedge clk);
      mem_rew = 0;
      @(negedge clk);
      rst = 1;
      #1;
      chk("abort_exp", int'(exp), 0);
      chk("abort_act", int'(act), 0);
      chk("abort_flag", int'(exp_change), 0);
      @(negedge clk);
      release_rst();
      wait_done();
      chk("abort_rerun_exp", int'(exp), 25);
      wr(4, 0, 1);
      run();
      chk("n1_exp", int'(exp), 0);
      wr(4, 0, 0);
      run();
      wr(4, 0, 2);
      node(1, 0, 511, 255, 1, ACT_PLAY);
      run();
`ifdef TREEVAL_SAT_EN
      chk("sat_exp", int'(exp), 511);
`else
      chk("sat_exp", int'(exp), -6);
`endif
      repeat (40) begin
         int n;
         n = $urandom_range(1, 16);
         wr(4, 0, n);
         for (int i = 0; i < n; i++)
            node(i, i == 0 ? 0 : $urandom_range(0, i - 1), int'($urandom_range(0, 1023)) - 512,
                 $urandom_range(0, 255), $urandom_range(0, 1), $urandom_range(0, 7));
         run();
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
      $finish;
   end
endmodule
